rotor_return: RTL and testbench
===============================

# rotor_return

Return-path (left-to-right) stage of one Enigma rotor. It applies the inverse wiring permutation (rotor I, inverse map UWYGADFPVZBECKMTHXSLRINQOJ) to a 5-bit symbol, offset by the rotor's current position and ring setting. It also owns the rotor position register, stepping and notch carry. It sits between the reflector output and the next rotor's return stage, and passes symbols through a single registered valid/ready stage.

## Interface
Parameters:
- NOTCH, 16: position whose step-away raises carry_out (Q→R).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  stage can accept a symbol.
- in_sym  in  5  input contact, legal 0..25.
- out_valid  out  1  output symbol valid.
- out_ready  in  1  downstream accepts.
- out_sym  out  5  output contact 0..25, or 31 on error.
- out_err  out  1  out_sym is invalid (in_sym > 25).
- step  in  1  advance position by one (mod 26).
- load  in  1  load position from load_pos.
- load_pos  in  5  new position; values > 25 are reduced mod 26.
- ring  in  5  ring setting 0..25 (only with ROTOR_RING_EN).
- position  out  5  current position.
- carry_out  out  1  one-cycle pulse: stepped away from NOTCH.

## Operation
- Offset: off = (position − ring) mod 26, where ring = 0 when ROTOR_RING_EN is undefined.
- Mapping: out_sym = (INV[(in_sym + off) mod 26] − off) mod 26. All sums use a 6-bit intermediate with a single conditional subtract/add of 26.
- Illegal in_sym (26..31): out_sym = 31 and out_err = 1. The symbol is still consumed.
- Handshake: in_ready = !out_valid || out_ready.
  - fire = in_valid && in_ready.
  - On fire, the output register loads and out_valid is set.
  - When out_valid && out_ready && !fire, out_valid clears.
- Output hold: while out_valid && !out_ready, out_sym and out_err are held stable.
- Position:
  - load has priority over step: position ← load_pos mod 26.
  - Otherwise, step advances position: 25 wraps to 0.
- carry_out is registered. It is 1 in the cycle after an accepted step (load = 0) whose pre-step position == NOTCH; otherwise 0.
- Same-cycle events: a symbol that fires in the same cycle as step/load is mapped with the pre-update position. The new position applies from the next cycle.

## Timing
- Reset values: out_valid 0, out_sym 0, out_err 0, position 0, carry_out 0. in_ready = 1 after reset.
- Latency: 1 cycle from fire to out_valid.
- Throughput: 1 symbol/cycle while out_ready = 1.
- Reset asserted mid-transfer discards the held symbol immediately (asynchronous). No output is produced for it.
- No combinational path from in_sym to out_sym; out_ready → in_ready is the only combinational path.

## Configuration
- ROTOR_RING_EN defined: the ring port exists and participates in the offset. ring > 25 is reduced mod 26.
- ROTOR_RING_EN undefined: the ring port is absent and offset = position.

## Structure
- Package enigma_pkg holds:
  - ALPHA_SIZE = 26 and SYM_INVALID = 31;
  - the 5-bit symbol typedef;
  - the rotor I inverse table as a constant function inv_wiring(sym);
  - default NOTCH = 16.
- Sub-module mod26_addsub: combinational (a ± b) mod 26 on 5-bit operands. It is instantiated for the input offset, the output offset and the position increment.

## Test plan
- Reset, position 0, ring 0: in_sym 4 → out_sym 0; in_sym 0 → out_sym 20; in_sym 18 → 18. Each result appears 1 cycle after fire.
- load_pos 1, then in_sym 0 → out_sym 21. Sweep all 26 inputs at every position and check each result is the exact inverse of the forward rotor mapping.
- Position 16 + step → position 17 next cycle and carry_out = 1 for exactly one cycle. Position 25 + step → 0 with carry_out = 0. Same-cycle load + step → position = load_pos.
- in_sym 27 → out_sym 31, out_err 1; the next legal symbol has out_err 0.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1. Require in_ready = 0 and out_sym stable. On release, back-to-back symbols arrive in order with none lost or duplicated.
- Assert rst while out_valid = 1 and position = 9: out_valid 0 and position 0 immediately. With ROTOR_RING_EN, position 0 and ring 1: in_sym 0 → out_sym 10.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: alphabet size, symbol type, rotor I inverse wiring
// and the mod-26 reduction used on externally supplied positions.
package enigma_pkg;
  localparam int   ALPHA_SIZE  = 26;
  localparam logic [4:0] SYM_INVALID = 5'd31;
  localparam int   NOTCH_DEF   = 16;

  typedef logic [4:0] sym_t;

  typedef struct packed {
    sym_t sym;
    logic err;
  } rsp_t;

  // Rotor I inverse map UWYGADFPVZBECKMTHXSLRINQOJ
  function automatic sym_t inv_wiring(input sym_t s);
    case (s)
      5'd0:  inv_wiring = 5'd20;
      5'd1:  inv_wiring = 5'd22;
      5'd2:  inv_wiring = 5'd24;
      5'd3:  inv_wiring = 5'd6;
      5'd4:  inv_wiring = 5'd0;
      5'd5:  inv_wiring = 5'd3;
      5'd6:  inv_wiring = 5'd5;
      5'd7:  inv_wiring = 5'd15;
      5'd8:  inv_wiring = 5'd21;
      5'd9:  inv_wiring = 5'd25;
      5'd10: inv_wiring = 5'd1;
      5'd11: inv_wiring = 5'd4;
      5'd12: inv_wiring = 5'd2;
      5'd13: inv_wiring = 5'd10;
      5'd14: inv_wiring = 5'd12;
      5'd15: inv_wiring = 5'd19;
      5'd16: inv_wiring = 5'd7;
      5'd17: inv_wiring = 5'd23;
      5'd18: inv_wiring = 5'd18;
      5'd19: inv_wiring = 5'd11;
      5'd20: inv_wiring = 5'd17;
      5'd21: inv_wiring = 5'd8;
      5'd22: inv_wiring = 5'd13;
      5'd23: inv_wiring = 5'd16;
      5'd24: inv_wiring = 5'd14;
      5'd25: inv_wiring = 5'd9;
      default: inv_wiring = SYM_INVALID;
    endcase
  endfunction

  function automatic sym_t mod26(input sym_t v);
    mod26 = (v >= 5'd26) ? v - 5'd26 : v;
  endfunction
endpackage

// File: rtl/rotor_return_if.sv
// Symbol stream between the reflector side and the next rotor's return stage.
interface rotor_return_if;
  import enigma_pkg::*;

  logic in_valid;
  logic in_ready;
  sym_t in_sym;
  logic out_valid;
  logic out_ready;
  sym_t out_sym;
  logic out_err;

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_sym, out_err
  );

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_sym, out_err
  );
endinterface

// File: rtl/mod26_addsub.sv
// Combinational (a +/- b) mod 26 for operands already in 0..25.
module mod26_addsub
  import enigma_pkg::*;
(
  input  sym_t a,
  input  sym_t b,
  input  logic sub,
  output sym_t y
);
  logic [5:0] s6;

  always_comb begin
    s6 = '0;
    if (sub) s6 = {1'b0, a} + ((a < b) ? 6'd26 : 6'd0) - {1'b0, b};
    else     s6 = {1'b0, a} + {1'b0, b};
    // 5-bit wrap of s6-26 is exact because s6 <= 51 here
    y = (s6 >= 6'd26) ? s6[4:0] - 5'd26 : s6[4:0];
  end
endmodule

// File: rtl/rotor_return.sv
// Return-path stage of Enigma rotor I: inverse wiring with position/ring offset,
// position register, stepping and notch carry. ROTOR_RING_EN adds the ring port.
module rotor_return
  import enigma_pkg::*;
#(
  parameter int NOTCH = NOTCH_DEF
) (
  input  logic clk,
  input  logic rst,
  rotor_return_if.slave bus,
  input  logic step,
  input  logic load,
  input  sym_t load_pos,
`ifdef ROTOR_RING_EN
  input  sym_t ring,
`endif
  output sym_t position,
  output logic carry_out
);
  localparam int STAGES = 1;

  sym_t pos_q, off, idx, inv, mapped, pos_inc;
  rsp_t rsp_d, rsp_q;
  logic [STAGES:0] vld_pipe;
  logic legal;

`ifdef ROTOR_RING_EN
  sym_t ring_r;
  assign ring_r = mod26(ring);
  mod26_addsub u_off (.a(pos_q), .b(ring_r), .sub(1'b1), .y(off));
`else
  assign off = pos_q;
`endif

  mod26_addsub u_in  (.a(bus.in_sym), .b(off),  .sub(1'b0), .y(idx));
  assign inv = inv_wiring(idx);
  mod26_addsub u_out (.a(inv),        .b(off),  .sub(1'b1), .y(mapped));
  mod26_addsub u_inc (.a(pos_q),      .b(5'd1), .sub(1'b0), .y(pos_inc));

  assign legal = (bus.in_sym < 5'd26);

  always_comb begin
    rsp_d = '{sym: mapped, err: 1'b0};
    if (!legal) rsp_d = '{sym: SYM_INVALID, err: 1'b1};
  end

  assign bus.in_ready = !vld_pipe[STAGES] || bus.out_ready;
  assign vld_pipe[0]  = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      rsp_q              <= '0;
    end else if (vld_pipe[0]) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      rsp_q              <= rsp_d;
    end else if (bus.out_ready) begin
      vld_pipe[STAGES:1] <= '0;
    end
  end

  // Mapping above uses pos_q, so a same-cycle step/load only affects later symbols
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= step && !load && (pos_q == sym_t'(NOTCH));
      if (load)      pos_q <= mod26(load_pos);
      else if (step) pos_q <= pos_inc;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_sym   = rsp_q.sym;
  assign bus.out_err   = rsp_q.err;
  assign position      = pos_q;
endmodule

// File: tb/tb_rotor_return.sv
// Directed bench for rotor_return: reset, mapping, stepping/carry, errors,
// backpressure, async reset and (with ROTOR_RING_EN) ring offset.
module tb_rotor_return;
  import enigma_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic step, load, carry_out;
  sym_t load_pos, position;
`ifdef ROTOR_RING_EN
  sym_t ring;
`endif

  int checks = 0;
  int failures = 0;

  // Forward rotor I wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ
  int fwd [26] = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};

  always #5 clk = ~clk;

  rotor_return_if bus();

  rotor_return #(.NOTCH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .step      (step),
    .load      (load),
    .load_pos  (load_pos),
`ifdef ROTOR_RING_EN
    .ring      (ring),
`endif
    .position  (position),
    .carry_out (carry_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    bus.in_valid = 1'b1;
    bus.in_sym   = 5'(s);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_pos(input int p);
    load     = 1'b1;
    load_pos = 5'(p);
    tick();
    load     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step = 1'b0; load = 1'b0; load_pos = '0;
`ifdef ROTOR_RING_EN
    ring = '0;
`endif
    bus.in_valid = 1'b0; bus.in_sym = '0; bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_sym",   32'(bus.out_sym),   0);
    chk("rst_err",   32'(bus.out_err),   0);
    chk("rst_pos",   32'(position),      0);
    chk("rst_carry", 32'(carry_out),     0);
    chk("rst_ready", 32'(bus.in_ready),  1);

    send(4);  chk("map4_valid", 32'(bus.out_valid), 1); chk("map4", 32'(bus.out_sym), 0);
    send(0);  chk("map0",  32'(bus.out_sym), 20);
    send(18); chk("map18", 32'(bus.out_sym), 18);
    tick();   chk("idle_valid", 32'(bus.out_valid), 0);

    set_pos(1); chk("load1_pos", 32'(position), 1);
    send(0);    chk("p1_map0", 32'(bus.out_sym), 21);

    // every input at every position must invert the forward wiring
    for (int p = 0; p < 26; p++) begin
      set_pos(p);
      chk($sformatf("sweep_pos%0d", p), 32'(position), p);
      for (int i = 0; i < 26; i++) begin
        int o;
        send(i);
        o = int'(bus.out_sym);
        chk($sformatf("sweep_p%0d_i%0d", p, i),
            32'((fwd[(o + p) % 26] - p + 26) % 26), i);
      end
    end

    set_pos(16);
    step = 1'b1; tick(); step = 1'b0;
    chk("notch_pos", 32'(position), 17);
    chk("notch_carry", 32'(carry_out), 1);
    tick();
    chk("notch_carry_drop", 32'(carry_out), 0);

    set_pos(25);
    step = 1'b1; tick(); step = 1'b0;
    chk("wrap_pos", 32'(position), 0);
    chk("wrap_carry", 32'(carry_out), 0);

    set_pos(16);
    load = 1'b1; load_pos = 5'd5; step = 1'b1; tick(); load = 1'b0; step = 1'b0;
    chk("ldstep_pos", 32'(position), 5);
    chk("ldstep_carry", 32'(carry_out), 0);

    set_pos(30); chk("load30_pos", 32'(position), 4);

    // symbol and step in the same cycle: old position maps the symbol
    set_pos(0);
    step = 1'b1; send(0); step = 1'b0;
    chk("same_cyc_sym", 32'(bus.out_sym), 20);
    chk("same_cyc_pos", 32'(position), 1);

    set_pos(0);
    send(27); chk("ill_sym", 32'(bus.out_sym), 31); chk("ill_err", 32'(bus.out_err), 1);
    send(4);  chk("post_ill_sym", 32'(bus.out_sym), 0); chk("post_ill_err", 32'(bus.out_err), 0);

    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sym = 5'd4;
    tick();
    bus.in_sym = 5'd0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 32'(bus.in_ready), 0);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_hold",  32'(bus.out_sym), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 1);
    tick();   chk("bp_seq0", 32'(bus.out_sym), 20); chk("bp_seq0_v", 32'(bus.out_valid), 1);
    bus.in_sym = 5'd18;
    tick();   chk("bp_seq1", 32'(bus.out_sym), 18);
    bus.in_sym = 5'd1;
    tick();   chk("bp_seq2", 32'(bus.out_sym), 22);
    bus.in_valid = 1'b0;
    tick();   chk("bp_drain", 32'(bus.out_valid), 0);

`ifdef ROTOR_RING_EN
    set_pos(0);
    ring = 5'd1;
    send(0); chk("ring1_map0", 32'(bus.out_sym), 10);
    ring = 5'd0;
`endif

    set_pos(9);
    bus.out_ready = 1'b0;
    send(3);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_pos", 32'(position), 9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 0);
    chk("async_rst_pos", 32'(position), 0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
